// File: rtl/bind_offset_sequencer_if.sv
`default_nettype none
// ============================================================================
// bind_offset_sequencer_if : command bus and mapper request bus of the
// bind offset sequencer.  Revision: 1.0
// ============================================================================
interface bind_offset_sequencer_if #(
  parameter int HV_ADDRESS_WIDTH = 20,
  parameter int LEN_WIDTH        = 3
);
  logic                        cmd_start;
  logic [HV_ADDRESS_WIDTH-1:0] cmd_hva;
  logic [HV_ADDRESS_WIDTH-1:0] cmd_hvb;
  logic [HV_ADDRESS_WIDTH-1:0] cmd_hvc;
  logic [LEN_WIDTH-1:0]        cmd_length;
  logic                        cmd_ready;
  logic                        cmd_done;
  logic                        cmd_error;
  logic                        valid;
  logic [HV_ADDRESS_WIDTH-1:0] hva;
  logic [HV_ADDRESS_WIDTH-1:0] hvb;
  logic [HV_ADDRESS_WIDTH-1:0] hvc;
  logic [HV_ADDRESS_WIDTH-1:0] hv_offset;
  logic                        done;

  // Sequencer side
  modport master (
    input  cmd_start, cmd_hva, cmd_hvb, cmd_hvc, cmd_length, done,
    output cmd_ready, cmd_done, cmd_error, valid, hva, hvb, hvc, hv_offset
  );

  // Control logic / mapper side
  modport slave (
    output cmd_start, cmd_hva, cmd_hvb, cmd_hvc, cmd_length, done,
    input  cmd_ready, cmd_done, cmd_error, valid, hva, hvb, hvc, hv_offset
  );
endinterface
`default_nettype wire

// File: rtl/bind_offset_sequencer.sv
`default_nettype none
// ============================================================================
// bind_offset_sequencer : walks word offsets 0..length-1 of a bind command,
// one mapper request per offset. Optional watchdog: BIND_SEQ_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module bind_offset_sequencer #(
  parameter int HV_ADDRESS_WIDTH       = 20,
  parameter int MAX_HYPERVECTOR_LENGTH = 4,
  parameter int LEN_WIDTH              = $clog2(MAX_HYPERVECTOR_LENGTH + 1),
  parameter int TIMEOUT_CYCLES         = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  bind_offset_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  generate
    if (MAX_HYPERVECTOR_LENGTH < 1 || TIMEOUT_CYCLES < 1 ||
        LEN_WIDTH > HV_ADDRESS_WIDTH) begin : g_bad_params
      $error("bind_offset_sequencer: illegal parameter combination");
    end
  endgenerate

  state_t                      state_q, state_d;
  logic [HV_ADDRESS_WIDTH-1:0] hva_q, hva_d;
  logic [HV_ADDRESS_WIDTH-1:0] hvb_q, hvb_d;
  logic [HV_ADDRESS_WIDTH-1:0] hvc_q, hvc_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic [LEN_WIDTH-1:0]        off_q, off_d;
  logic                        valid_q, valid_d;
  logic                        ready_q, ready_d;
  logic                        cmd_done_q, cmd_done_d;
  logic                        err_q, err_d;

`ifdef BIND_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
`endif

  always_comb begin
    state_d    = state_q;
    hva_d      = hva_q;
    hvb_d      = hvb_q;
    hvc_d      = hvc_q;
    len_d      = len_q;
    off_d      = off_q;
    valid_d    = valid_q;
    ready_d    = ready_q;
    cmd_done_d = 1'b0;
    err_d      = err_q;
`ifdef BIND_SEQ_TIMEOUT_EN
    tmo_d      = tmo_q;
    tmo_hit    = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_start) begin
          hva_d   = bus.cmd_hva;
          hvb_d   = bus.cmd_hvb;
          hvc_d   = bus.cmd_hvc;
          len_d   = bus.cmd_length;
          off_d   = '0;
          err_d   = 1'b0;
          ready_d = 1'b0;
          if (bus.cmd_length == '0) begin
            state_d = S_FINISH;
          end else if (bus.cmd_length > LEN_WIDTH'(MAX_HYPERVECTOR_LENGTH)) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            valid_d = 1'b1;
            state_d = S_ISSUE;
`ifdef BIND_SEQ_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end

      // done is still high on entry; only a sampled low means acceptance.
      S_ISSUE: begin
        if (!bus.done) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
`ifdef BIND_SEQ_TIMEOUT_EN
          tmo_d   = '0;
        end else if (tmo_hit) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
`endif
        end
      end

      S_WAIT: begin
        if (bus.done) begin
          if (off_q == len_q - LEN_WIDTH'(1)) begin
            state_d = S_FINISH;
          end else begin
            off_d   = off_q + LEN_WIDTH'(1);
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end
`ifdef BIND_SEQ_TIMEOUT_EN
          tmo_d = '0;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
`endif
        end
      end

      S_FINISH: begin
        cmd_done_d = 1'b1;
        ready_d    = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hva_q      <= '0;
      hvb_q      <= '0;
      hvc_q      <= '0;
      len_q      <= '0;
      off_q      <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      cmd_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hva_q      <= hva_d;
      hvb_q      <= hvb_d;
      hvc_q      <= hvc_d;
      len_q      <= len_d;
      off_q      <= off_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      cmd_done_q <= cmd_done_d;
      err_q      <= err_d;
    end
  end

`ifdef BIND_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign bus.cmd_ready = ready_q;
  assign bus.cmd_done  = cmd_done_q;
  assign bus.cmd_error = err_q;
  assign bus.valid     = valid_q;
  assign bus.hva       = hva_q;
  assign bus.hvb       = hvb_q;
  assign bus.hvc       = hvc_q;
  assign bus.hv_offset = HV_ADDRESS_WIDTH'(off_q);

endmodule
`default_nettype wire

// File: tb/tb_bind_offset_sequencer.sv
`default_nettype none
// ============================================================================
// tb_bind_offset_sequencer : directed + randomized bench with a mapper model
// and a request-list reference model.  Revision: 1.0
// ============================================================================
module tb_bind_offset_sequencer;
  localparam int W    = 20;
  localparam int MAXL = 4;
  localparam int LW   = 3;
  localparam int TMO  = 8;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] off;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bind_offset_sequencer_if #(.HV_ADDRESS_WIDTH(W), .LEN_WIDTH(LW)) bus ();

  bind_offset_sequencer #(
    .HV_ADDRESS_WIDTH(W), .MAX_HYPERVECTOR_LENGTH(MAXL),
    .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int   checks = 0;
  int   failures = 0;
  req_t obs_q[$];
  req_t exp_q[$];
  int   done_cnt = 0;
  int   valid_cnt = 0;
  int   proto_err = 0;
  bit   mapper_en = 1'b1;
  int   fix_d1 = -1;
  int   fix_d2 = -1;

  task automatic check(input string tag, input logic [79:0] o, input logic [79:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, o, e);
      $error("check %s failed", tag);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.cmd_done === 1'b1) done_cnt++;
      if (bus.valid === 1'b1) valid_cnt++;
    end
  end

  // Mapper model: accepts a request, drops done after d1 cycles, raises it d2 later.
  initial begin
    int d1, d2;
    bus.done = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (mapper_en && bus.valid === 1'b1) begin
        obs_q.push_back({bus.hva, bus.hvb, bus.hvc, bus.hv_offset});
        d1 = (fix_d1 >= 0) ? fix_d1 : int'($urandom_range(0, 3));
        d2 = (fix_d2 >= 0) ? fix_d2 : int'($urandom_range(1, 6));
        repeat (d1) begin
          @(posedge clk); #1;
          if (bus.valid !== 1'b1) proto_err++;
        end
        bus.done = 1'b0;
        repeat (d2) begin
          @(posedge clk); #1;
          if (bus.valid === 1'b1) proto_err++;
        end
        bus.done = 1'b1;
      end
    end
  end

  // Reference: a legal command requests every offset 0..len-1 with its own bases.
  task automatic build_exp(input logic [W-1:0] a, b, c, input int len);
    exp_q.delete();
    if (len >= 1 && len <= MAXL)
      for (int i = 0; i < len; i++) exp_q.push_back({a, b, c, W'(i)});
  endtask

  task automatic run_cmd(input logic [W-1:0] a, b, c, input int len, input int dup_at);
    bit got;
    int n;
    obs_q.delete();
    done_cnt = 0; valid_cnt = 0; proto_err = 0;
    build_exp(a, b, c, len);
    bus.cmd_hva = a; bus.cmd_hvb = b; bus.cmd_hvc = c;
    bus.cmd_length = LW'(len);
    bus.cmd_start = 1'b1;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    got = 1'b0;
    for (int cyc = 0; cyc < 400 && !got; cyc++) begin
      @(negedge clk);
      if (bus.cmd_done === 1'b1) got = 1'b1;
      if (dup_at > 0 && cyc == dup_at) begin
        bus.cmd_hva = ~a; bus.cmd_hvb = ~b; bus.cmd_hvc = ~c;
        bus.cmd_length = LW'(1);
        bus.cmd_start = 1'b1;
      end else if (dup_at > 0 && cyc == dup_at + 1) begin
        bus.cmd_start = 1'b0;
      end
    end
    bus.cmd_start = 1'b0;
    check("cmd_done_seen", 80'(got), 80'(1));
    repeat (4) @(negedge clk);
    check("done_pulses", 80'(done_cnt), 80'(1));
    check("cmd_error", 80'(bus.cmd_error), 80'(len > MAXL));
    check("cmd_ready_after", 80'(bus.cmd_ready), 80'(1));
    check("req_count", 80'(obs_q.size()), 80'(exp_q.size()));
    check("protocol", 80'(proto_err), 80'(0));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("request", 80'(obs_q[i]), 80'(exp_q[i]));
    if (len == 0 || len > MAXL) check("no_valid", 80'(valid_cnt), 80'(0));
  endtask

  task automatic short_cmd(input int len);
    done_cnt = 0; valid_cnt = 0;
    bus.cmd_hva = 20'h11111; bus.cmd_hvb = 20'h22222; bus.cmd_hvc = 20'h33333;
    bus.cmd_length = LW'(len);
    bus.cmd_start = 1'b1;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    check("short_done_early", 80'(bus.cmd_done), 80'(0));
    @(posedge clk); #1;
    check("short_done_t2", 80'(bus.cmd_done), 80'(1));
    check("short_ready", 80'(bus.cmd_ready), 80'(1));
    check("short_error", 80'(bus.cmd_error), 80'(len > MAXL));
    @(posedge clk); #1;
    check("short_done_once", 80'(bus.cmd_done), 80'(0));
    check("short_no_valid", 80'(valid_cnt), 80'(0));
  endtask

  initial begin
    bit hit;
    reset = 1'b1;
    bus.cmd_start = 1'b0;
    bus.cmd_hva = '0; bus.cmd_hvb = '0; bus.cmd_hvc = '0; bus.cmd_length = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 80'(bus.cmd_ready), 80'(1));
    check("rst_done", 80'(bus.cmd_done), 80'(0));
    check("rst_error", 80'(bus.cmd_error), 80'(0));
    check("rst_valid", 80'(bus.valid), 80'(0));
    check("rst_bases", 80'({bus.hva, bus.hvb, bus.hvc}), 80'(0));
    check("rst_offset", 80'(bus.hv_offset), 80'(0));
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    fix_d1 = 2; fix_d2 = 5;
    run_cmd(20'h00100, 20'h00200, 20'h00300, 4, 0);
    fix_d1 = -1; fix_d2 = -1;

    short_cmd(0);
    short_cmd(5);
    check("err_sticky", 80'(bus.cmd_error), 80'(1));
    run_cmd(20'h0ABCD, 20'h01234, 20'h0FFFF, 1, 0);

    run_cmd(20'h00AAA, 20'h00BBB, 20'h00CCC, 3, 3);

    for (int k = 0; k < 8; k++)
      run_cmd(W'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 7)), 0);

    // Abort with reset while the mapper is busy on offset 1.
    fix_d1 = 1; fix_d2 = 5;
    obs_q.delete(); done_cnt = 0;
    bus.cmd_hva = 20'h00500; bus.cmd_hvb = 20'h00600; bus.cmd_hvc = 20'h00700;
    bus.cmd_length = LW'(4);
    bus.cmd_start = 1'b1;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      @(negedge clk);
      if (obs_q.size() == 2 && bus.valid === 1'b0 && bus.done === 1'b0) hit = 1'b1;
    end
    check("reached_wait_off1", 80'(hit), 80'(1));
    check("wait_offset", 80'(bus.hv_offset), 80'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_valid", 80'(bus.valid), 80'(0));
    check("abort_offset", 80'(bus.hv_offset), 80'(0));
    check("abort_ready", 80'(bus.cmd_ready), 80'(1));
    valid_cnt = 0;
    repeat (12) @(negedge clk);
    check("abort_no_done", 80'(done_cnt), 80'(0));
    check("abort_no_valid", 80'(valid_cnt), 80'(0));
    fix_d1 = -1; fix_d2 = -1;
    run_cmd(20'h00042, 20'h00043, 20'h00044, 2, 0);

`ifdef BIND_SEQ_TIMEOUT_EN
    mapper_en = 1'b0;
    done_cnt = 0; valid_cnt = 0;
    bus.cmd_length = LW'(2);
    bus.cmd_start = 1'b1;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge clk);
      if (bus.cmd_done === 1'b1) hit = 1'b1;
    end
    check("tmo_done_seen", 80'(hit), 80'(1));
    check("tmo_valid_cycles", 80'(valid_cnt), 80'(TMO));
    check("tmo_error", 80'(bus.cmd_error), 80'(1));
    repeat (3) @(negedge clk);
    check("tmo_ready", 80'(bus.cmd_ready), 80'(1));
    check("tmo_one_done", 80'(done_cnt), 80'(1));
    mapper_en = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
